startlevel_gen: RTL

STARTLEVEL_GEN -- requirements
Module: startlevel_gen

---
 rtl/startlevel_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/startlevel_gen.sv
// startlevel_gen: sweeps a 9-bit start level for a downstream k counter.
// A sweep begins at base_level and steps by 'step' every dwell+1 cycles for
// num_steps changes, then holds the last level for one more dwell period.
// Optional feature macro: STARTLEVEL_WRAP_EN. When it is defined the level wraps
// modulo 512. When it is undefined the level clamps at 511, ovf is set, and the
// sweep ends.
module startlevel_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [8:0] base_level,
  input  logic [8:0] step,
  input  logic [7:0] dwell,
  input  logic [5:0] num_steps,
  output logic [8:0] startlevel,
  output logic       server_counter_start,
  output logic       level_strobe,
  output logic [5:0] k_expected,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [8:0] step_q;
  logic [7:0] dwell_q;
  logic [5:0] nsteps_q;
  logic [7:0] dwell_cnt;
  logic [5:0] step_cnt;
  logic [8:0] next_level;
  logic       step_ovf;
  logic       level_due;

  // A level change is due when the dwell period has expired and steps remain.
  assign level_due = (state == S_RUN) && (dwell_cnt == 8'd0) && (step_cnt < nsteps_q);

`ifdef STARTLEVEL_WRAP_EN
  assign next_level = startlevel + step_q;
  assign step_ovf   = 1'b0;
`else
  logic [9:0] level_sum;
  assign level_sum  = {1'b0, startlevel} + {1'b0, step_q};
  assign next_level = level_sum[8:0];
  assign step_ovf   = level_sum[9];
`endif

  assign busy = (state == S_ARM) || (state == S_RUN);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Abort pulls any active state back to IDLE. In IDLE, abort blocks a start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_ARM;
      S_ARM:  state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                                        state_nxt = S_IDLE;
        else if (dwell_cnt == 8'd0 && step_cnt >= nsteps_q) state_nxt = S_DONE;
        else if (level_due && step_ovf)                   state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: config capture, dwell/step counting, level and k updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      startlevel           <= 9'd0;
      server_counter_start <= 1'b0;
      level_strobe         <= 1'b0;
      k_expected           <= 6'd1;
      ovf                  <= 1'b0;
      step_q               <= 9'd0;
      dwell_q              <= 8'd0;
      nsteps_q             <= 6'd0;
      dwell_cnt            <= 8'd0;
      step_cnt             <= 6'd0;
    end else begin
      level_strobe         <= 1'b0;
      server_counter_start <= (state_nxt == S_ARM) || (state_nxt == S_RUN);
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            step_q     <= (step == 9'd0) ? 9'd1 : step;
            dwell_q    <= dwell;
            nsteps_q   <= num_steps;
            startlevel <= base_level;
            ovf        <= 1'b0;
          end
        end
        S_ARM: begin
          if (!abort) begin
            k_expected <= 6'd1;
            dwell_cnt  <= dwell_q;
            step_cnt   <= 6'd0;
          end
        end
        S_RUN: begin
          if (!abort) begin
            if (dwell_cnt != 8'd0) begin
              dwell_cnt <= dwell_cnt - 8'd1;
            end else if (level_due) begin
              if (step_ovf) begin
                startlevel <= 9'd511;
                ovf        <= 1'b1;
              end else begin
                startlevel   <= next_level;
                level_strobe <= 1'b1;
                if (k_expected != 6'd63) k_expected <= k_expected + 6'd1;
                step_cnt  <= step_cnt + 6'd1;
                dwell_cnt <= dwell_q;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
